// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared mode encodings and width default for the programmable divider
package clkdiv_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int DEFAULT_CNT_WIDTH = 32;

endpackage

// File: rtl/clock_divider_prog_if.sv
// rtl/clock_divider_prog_if.sv - control and output bundle of the programmable divider
interface clock_divider_prog_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
    logic                 en;
    logic                 load;
    logic [CNT_WIDTH-1:0] div_in;
    logic                 mode_in;
    logic                 out_clk;
    logic                 tick;
    logic                 busy;

    modport master (
        output en, load, div_in, mode_in,
        input  out_clk, tick, busy
    );

    modport slave (
        input  en, load, div_in, mode_in,
        output out_clk, tick, busy
    );
endinterface

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable divider producing a 50% clock or a one-cycle strobe
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int   CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int   DEFAULT_HALF = 4999,
    parameter logic DEFAULT_MODE = MODE_TOGGLE
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_divider_prog_if.slave  bus
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] active_div;
    logic                 active_mode;
    logic [CNT_WIDTH-1:0] pend_div;
    logic                 pend_mode;
    logic                 pend_valid;
    logic                 out_q;
    logic                 tick_q;

    logic                 at_term;
    logic                 mode_chg;
    logic                 out_next;

    // A mode switch applied at a terminal event restarts the output from 0 in the new mode.
    always_comb begin
        at_term  = (cnt == active_div);
        mode_chg = at_term && pend_valid && (pend_mode != active_mode);
        out_next = out_q;
        if (mode_chg) begin
            out_next = 1'b0;
        end else if (active_mode == MODE_PULSE) begin
            out_next = at_term;
        end else begin
            out_next = out_q ^ at_term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            active_div  <= CNT_WIDTH'(DEFAULT_HALF);
            active_mode <= DEFAULT_MODE;
            pend_div    <= '0;
            pend_mode   <= MODE_TOGGLE;
            pend_valid  <= 1'b0;
            out_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else if (bus.en) begin
            tick_q <= at_term;
            out_q  <= out_next;
            if (at_term) begin
                cnt <= '0;
                if (pend_valid) begin
                    active_div  <= pend_div;
                    active_mode <= pend_mode;
                end
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            // A load coinciding with a transfer becomes the next pending request.
            if (bus.load) begin
                pend_div   <= bus.div_in;
                pend_mode  <= bus.mode_in;
                pend_valid <= 1'b1;
            end else if (at_term) begin
                pend_valid <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
            if (bus.load) begin
                active_div  <= bus.div_in;
                active_mode <= bus.mode_in;
                cnt         <= '0;
                pend_valid  <= 1'b0;
                if (bus.mode_in != active_mode) begin
                    out_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_clk = out_q;
    assign bus.tick    = tick_q;
    assign bus.busy    = pend_valid;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
module tb_clock_divider_prog;
    import clkdiv_pkg::*;

    localparam int W  = 16;
    localparam int DH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_divider_prog_if #(.CNT_WIDTH(W)) bus();

    clock_divider_prog #(
        .CNT_WIDTH   (W),
        .DEFAULT_HALF(DH),
        .DEFAULT_MODE(MODE_TOGGLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int   n;
        logic mode;
    } req_t;

    int   m_n;
    int   m_pos;
    logic m_mode;
    logic m_out;
    logic m_tick;
    req_t m_pend[$];

    typedef struct {
        logic rst, en, load;
        logic [W-1:0] div;
        logic mode;
        logic eo, et, eb;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Reference: position within the current period, plus a queue holding at most one pending request.
    task automatic model_step();
        logic fired, chg;
        req_t r;
        if (rst) begin
            m_n = DH; m_mode = MODE_TOGGLE; m_pos = 0;
            m_pend.delete(); m_out = 1'b0; m_tick = 1'b0;
        end else if (bus.en) begin
            fired = (m_pos == m_n);
            chg   = 1'b0;
            if (fired) begin
                m_pos = 0;
                if (m_pend.size() > 0) begin
                    r = m_pend.pop_front();
                    chg = (r.mode != m_mode);
                    m_n = r.n;
                    m_mode = r.mode;
                end
            end else begin
                m_pos++;
            end
            if (chg) m_out = 1'b0;
            else if (m_mode == MODE_PULSE) m_out = fired;
            else m_out = m_out ^ fired;
            m_tick = fired;
            if (bus.load) begin
                m_pend.delete();
                r.n = int'(bus.div_in);
                r.mode = bus.mode_in;
                m_pend.push_back(r);
            end
        end else begin
            m_tick = 1'b0;
            if (bus.load) begin
                if (bus.mode_in != m_mode) m_out = 1'b0;
                m_n = int'(bus.div_in);
                m_mode = bus.mode_in;
                m_pos = 0;
                m_pend.delete();
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input int d, input logic m);
        rst = r; bus.en = e; bus.load = l; bus.div_in = W'(d); bus.mode_in = m;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("model_out_clk", bus.out_clk, m_out);
        chk("model_tick", bus.tick, m_tick);
        chk("model_busy", bus.busy, m_pend.size() != 0);
    endtask

    initial begin
        logic held, prev;
        int pulses;
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);

        vecs[0] = '{1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 10; k++)
            vecs[k] = '{1'b0, 1'b1, 1'b0, '0, 1'b0, (k >= 5 && k < 10), (k == 5 || k == 10), 1'b0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, int'(vecs[i].div), vecs[i].mode);
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("vec%0d_out_clk", i), bus.out_clk, vecs[i].eo);
            chk($sformatf("vec%0d_tick", i), bus.tick, vecs[i].et);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].eb);
        end

        // Reload N=1 while counter=2: current half-period still ends with N=4.
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(); step();
        drive(1'b0, 1'b1, 1'b1, 1, MODE_TOGGLE);
        step();
        chk("load_busy", bus.busy, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step();
        chk("busy_before_switch", bus.busy, 1'b1);
        step();
        chk("switch_busy", bus.busy, 1'b0);
        chk("switch_tick", bus.tick, 1'b1);
        chk("switch_out", bus.out_clk, 1'b1);
        step();
        chk("short_half_hold", bus.out_clk, 1'b1);
        step();
        chk("short_half_toggle", bus.out_clk, 1'b0);

        // Direct load into pulse mode, N=3.
        drive(1'b0, 1'b0, 1'b1, 3, MODE_PULSE);
        step();
        chk("direct_load_busy", bus.busy, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("pulse_eq_tick", bus.out_clk, bus.tick);
            if (bus.out_clk) pulses++;
        end
        chk("pulse_count", pulses == 3, 1'b1);

        // N=0 toggle gives clk/2; N=0 pulse holds high.
        drive(1'b0, 1'b0, 1'b1, 0, MODE_TOGGLE);
        step();
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        prev = bus.out_clk;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("n0_toggle", bus.out_clk, ~prev);
            prev = bus.out_clk;
        end
        drive(1'b0, 1'b0, 1'b1, 0, MODE_PULSE);
        step();
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("n0_pulse", bus.out_clk, 1'b1);
        end

        // Freeze at counter=3 for 7 cycles, then resume.
        drive(1'b0, 1'b0, 1'b1, 4, MODE_TOGGLE);
        step();
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(); step(); step();
        held = bus.out_clk;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("freeze_tick", bus.tick, 1'b0);
            chk("freeze_out", bus.out_clk, held);
        end
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step();
        chk("resume_hold", bus.out_clk, held);
        step();
        chk("resume_toggle", bus.out_clk, ~held);

        // Reset while a load of N=9 is pending.
        drive(1'b0, 1'b1, 1'b1, 9, MODE_TOGGLE);
        step();
        chk("pend9_busy", bus.busy, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 7, MODE_PULSE);
        step();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out", bus.out_clk, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dflt_low", bus.out_clk, 1'b0);
        end
        step();
        chk("dflt_after_rst", bus.out_clk, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
                  int'($urandom % 8), logic'($urandom % 2));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable clock divider and tick generator; the parametrised successor to the fixed 10 kHz divider.
- Produces either a 50%-duty divided clock (toggle mode) or a one-cycle strobe (pulse mode) from the single system clock.
- Divisor and mode can be changed at runtime and take effect glitch-free at a period boundary.
- Used by display-scan, debounce and demo logic that currently needs one hard-coded divider per rate.

Parameters:
- CNT_WIDTH, 32, width of the counter and divisor registers.
- DEFAULT_HALF, 4999, terminal count after reset. With a 100 MHz clk this gives 10 kHz in toggle mode.
- DEFAULT_MODE, 0, mode after reset (0 = toggle, 1 = pulse).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; low freezes counter and outputs.
- load  input  1  one-cycle strobe; captures div_in and mode_in into the pending registers.
- div_in  input  CNT_WIDTH  requested terminal count N.
- mode_in  input  1  requested mode.
- out_clk  output  1  divided clock (toggle mode) or strobe (pulse mode); registered.
- tick  output  1  one-cycle pulse on every terminal-count event, in both modes; registered.
- busy  output  1  high while a pending load has not yet been applied.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset (rst=1 at a posedge): counter=0, active_div=DEFAULT_HALF, active_mode=DEFAULT_MODE, pending cleared, out_clk=0, tick=0, busy=0. Reset overrides en and load in the same cycle.
- Counting: when en=1, the counter increments each cycle from 0 to active_div. At counter==active_div it wraps to 0 and a terminal event fires.
- Toggle mode: out_clk inverts at each terminal event. Period = 2*(N+1) clk cycles, 50% duty. N=0 gives clk/2.
- Pulse mode: out_clk=1 for exactly the cycle after the terminal event, else 0. Period = N+1 cycles. N=0 gives out_clk held at 1.
- tick: high for the one cycle following each terminal event, in both modes.
- Latency: out_clk and tick change on the clock edge at which counter==active_div is sampled. There is no combinational path from inputs to outputs.
- Load while en=1:
  - div_in and mode_in are stored as pending and busy goes to 1 the next cycle.
  - Pending values are transferred to the active registers at the next terminal event. busy clears in the same cycle as the transfer.
  - The current half-period always completes with the old N, so there are no runt pulses.
- Load while en=0: values are applied directly to the active registers at the next edge. counter is reset to 0; busy is never asserted.
- Load in the same cycle as a terminal event: the terminal event uses the old N. The new values become pending and are applied at the following terminal event.
- Repeated loads before apply: the last load wins.
- Mode change applied at a terminal event: toggle to pulse forces out_clk=0 on the next edge; pulse to toggle starts from out_clk=0.
- en=0: counter, out_clk and busy hold; tick=0. Resuming en=1 continues from the held count.
- Arithmetic: the counter compares for equality only, with unsigned CNT_WIDTH wrap. If active_div is reduced below the current count, the change can only apply at a terminal event, so overrun is impossible.

Decomposition:
- Shared package clkdiv_pkg holds MODE_TOGGLE=1'b0, MODE_PULSE=1'b1, and the default width constant.
- Single module; the pending/active register pair is small enough that no sub-module is needed.

Test Plan:
- Reset then en=1, div_in unused, DEFAULT_HALF=4 (bench override) -> out_clk toggles every 5 cycles (period 10); tick pulses every 5 cycles; first toggle 5 cycles after reset release.
- Toggle mode, N=4 running; load N=1 mid-half-period (counter=2) -> current half-period still lasts 5 cycles, then half-periods of 2; busy high from the load until the switch-over cycle.
- Pulse mode via load with en=0, N=3 -> out_clk is a one-cycle high every 4 cycles; out_clk equals tick; busy never asserted.
- N=0 in toggle mode -> out_clk = clk/2 (toggles every cycle). N=0 in pulse mode -> out_clk constant 1 after the first terminal event.
- en deasserted for 7 cycles at counter=3 -> outputs and counter frozen, tick=0; after en=1, the next toggle occurs 2 cycles later (N=4).
- rst asserted mid-pending-load with N=4 active and load N=9 pending -> after reset active N=DEFAULT_HALF, busy=0, out_clk=0; pending N=9 discarded.
